// File: rtl/pe_layer_sched_pkg.sv
// Shared widths, FSM encoding and LLR saturation helper for the SC decoder f/g layer scheduler.
package pe_layer_sched_pkg;
    localparam int LLR_W       = 6;
    localparam int P           = 4;
    localparam int LOG_P       = 2;
    localparam int MAX_LOG_LEN = 10;
    localparam int AW          = 10;

    typedef logic signed [LLR_W-1:0] llr_t;

    localparam llr_t LLR_MAX = llr_t'((1 << (LLR_W-1)) - 1);
    localparam llr_t LLR_MIN = llr_t'(1 << (LLR_W-1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // Clamp an LLR_W+1 bit sum: the top two bits disagree only on overflow.
    function automatic llr_t sat_llr(input logic signed [LLR_W:0] x);
        case ({x[LLR_W], x[LLR_W-1]})
            2'b01:   return LLR_MAX;
            2'b10:   return LLR_MIN;
            default: return x[LLR_W-1:0];
        endcase
    endfunction
endpackage

// File: rtl/pe_layer_sched_pe.sv
// One combinational f/g processing-element lane.
module pe_layer_sched_pe
    import pe_layer_sched_pkg::*;
(
    input  logic is_f,
    input  logic s,
    input  llr_t a,
    input  llr_t b,
    output llr_t y
);
    logic [LLR_W-1:0]      mag_a, mag_b, mag_min;
    logic signed [LLR_W:0] g_sum;

    always_comb begin
        // Magnitudes are unsigned, so the most negative LLR maps to +2^(LLR_W-1).
        mag_a   = a[LLR_W-1] ? -a : a;
        mag_b   = b[LLR_W-1] ? -b : b;
        mag_min = (mag_a < mag_b) ? mag_a : mag_b;
        g_sum   = s ? ({b[LLR_W-1], b} - {a[LLR_W-1], a})
                    : ({b[LLR_W-1], b} + {a[LLR_W-1], a});
        if (is_f)
            y = (a[LLR_W-1] ^ b[LLR_W-1]) ? llr_t'(-mag_min) : llr_t'(mag_min);
        else
            y = sat_llr(g_sum);
    end
endmodule

// File: rtl/pe_layer_sched.sv
// Walks one f/g layer word by word: reads left/right halves, runs P PE lanes, writes the child vector.
module pe_layer_sched
    import pe_layer_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_f,
    input  logic [3:0]            log_len,
    input  logic [AW-1:0]         src_base,
    input  logic [AW-1:0]         dst_base,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr_a,
    output logic [AW-1:0]         rd_addr_b,
    input  logic [P*LLR_W-1:0]    rd_data_a,
    input  logic [P*LLR_W-1:0]    rd_data_b,
    output logic [AW-1:0]         ps_addr,
    input  logic [P-1:0]          ps_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [P*LLR_W-1:0]    wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int STAGES = 2;

    state_t                 state, state_nxt;
    logic [AW-1:0]          cnt, w_q, src_q, dst_q, waddr_q;
    logic                   is_f_q, last_q;
    logic [STAGES:1]        vld_pipe;
    logic                   legal, start_ok, start_bad, last_rd;
    logic [P-1:0][LLR_W-1:0] pe_y;

    assign legal     = (log_len >= 4'(LOG_P + 1)) && (log_len <= 4'(MAX_LOG_LEN));
    assign start_ok  = (state == S_IDLE) && start && legal;
    assign start_bad = (state == S_IDLE) && start && !legal;
    assign last_rd   = (cnt == w_q - AW'(1));
    assign wr_en     = vld_pipe[STAGES];

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        ps_addr   = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN: begin
                rd_en     = 1'b1;
                rd_addr_a = src_q + cnt;
                rd_addr_b = src_q + w_q + cnt;
                ps_addr   = cnt;
                if (last_rd) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        pe_layer_sched_pe u_pe (
            .is_f (is_f_q),
            .s    (ps_data[k]),
            .a    (rd_data_a[k*LLR_W +: LLR_W]),
            .b    (rd_data_b[k*LLR_W +: LLR_W]),
            .y    (pe_y[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            w_q      <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            is_f_q   <= 1'b0;
            waddr_q  <= '0;
            last_q   <= 1'b0;
            vld_pipe <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= start_bad;
            if (start_ok) begin
                is_f_q <= is_f;
                w_q    <= AW'(1) << (log_len - 4'(LOG_P + 1));
                src_q  <= src_base;
                dst_q  <= dst_base;
                cnt    <= '0;
            end else if (state == S_RUN) begin
                cnt <= cnt + AW'(1);
            end
            // Stage 1 tracks the word whose read data is returning; stage 2 is the write.
            vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
            last_q   <= rd_en && last_rd;
            waddr_q  <= dst_q + cnt;
            wr_addr  <= vld_pipe[1] ? waddr_q : '0;
            wr_data  <= vld_pipe[1] ? pe_y : '0;
            done     <= vld_pipe[1] && last_q;
        end
    end
endmodule

// File: tb/tb_pe_layer_sched.sv
// Directed bench for pe_layer_sched with a behavioural LLR/partial-sum memory and write monitor.
module tb_pe_layer_sched;
    import pe_layer_sched_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 is_f = 1'b0;
    logic [3:0]           log_len = '0;
    logic [AW-1:0]        src_base = '0, dst_base = '0;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr_a, rd_addr_b, ps_addr, wr_addr;
    logic [P*LLR_W-1:0]   rd_data_a = '0, rd_data_b = '0, wr_data;
    logic [P-1:0]         ps_data = '0;
    logic                 wr_en, busy, done, err;

    logic [P*LLR_W-1:0]   mem [0:(1<<AW)-1];
    logic [P-1:0]         psm [0:(1<<AW)-1];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int nz_cnt = 0;
    int wr_a_q[$], wr_c_q[$], rd_a_q[$], rd_b_q[$], rd_c_q[$], done_q[$], err_q[$];
    logic [P*LLR_W-1:0] wr_d_q[$];

    pe_layer_sched dut (
        .clk(clk), .rst(rst), .start(start), .is_f(is_f), .log_len(log_len),
        .src_base(src_base), .dst_base(dst_base), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .ps_addr(ps_addr), .ps_data(ps_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
            ps_data   <= psm[ps_addr];
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_a_q.push_back(int'(wr_addr));
            wr_d_q.push_back(wr_data);
            wr_c_q.push_back(cyc);
        end
        if (rd_en) begin
            rd_a_q.push_back(int'(rd_addr_a));
            rd_b_q.push_back(int'(rd_addr_b));
            rd_c_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
        if (err)  err_q.push_back(cyc);
        if (busy) busy_cnt++;
        if (rd_en | wr_en | busy | done | err | (|rd_addr_a) | (|rd_addr_b) |
            (|ps_addr) | (|wr_addr) | (|wr_data)) nz_cnt++;
    end

    function automatic logic [P*LLR_W-1:0] pk(input int l0, l1, l2, l3);
        return {LLR_W'(l3), LLR_W'(l2), LLR_W'(l1), LLR_W'(l0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
        rd_a_q.delete(); rd_b_q.delete(); rd_c_q.delete();
        done_q.delete(); err_q.delete();
        busy_cnt = 0;
        nz_cnt = 0;
    endtask

    task automatic launch(input logic f, input logic [3:0] ll, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, output int t);
        @(posedge clk); #1;
        clr();
        is_f = f; log_len = ll; src_base = s; dst_base = d; start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 32'(done_q.size() >= n), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0;
        int bad;
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = '0;
            psm[i] = '0;
        end
        mem[100] = pk(5, -3, 31, -32);
        mem[101] = pk(1, 2, 3, 4);
        mem[102] = pk(-2, -7, -32, 4);
        mem[103] = pk(-1, -2, -3, -4);
        mem[300] = pk(31, -32, -20, 3);
        mem[301] = pk(1, 5, -20, 4);
        psm[0]   = 4'b1010;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // f layer, W=2
        launch(1'b1, 4'd4, 10'd100, 10'd200, t0);
        wait_done(1, 50);
        chk("f_wr_cnt", wr_a_q.size(), 2);
        chk("f_wr0_addr", wr_a_q[0], 200);
        chk("f_wr1_addr", wr_a_q[1], 201);
        chk("f_wr0_data", 32'(wr_d_q[0]), 32'(pk(-2, 3, -31, -4)));
        chk("f_wr1_data", 32'(wr_d_q[1]), 32'(pk(-1, -2, -3, -4)));
        chk("f_wr0_cyc", wr_c_q[0], t0 + 3);
        chk("f_wr1_cyc", wr_c_q[1], t0 + 4);
        chk("f_done_cyc", done_q[0], t0 + 4);
        chk("f_rd0_cyc", rd_c_q[0], t0 + 1);
        chk("f_rd0_addr_b", rd_b_q[0], 102);
        chk("f_busy_cnt", busy_cnt, 4);

        // g layer saturation, W=1
        launch(1'b0, 4'd3, 10'd300, 10'd400, t0);
        wait_done(1, 50);
        chk("g_wr_cnt", wr_a_q.size(), 1);
        chk("g_wr_addr", wr_a_q[0], 400);
        chk("g_wr_data", 32'(wr_d_q[0]), 32'(pk(31, 31, -32, 1)));
        chk("g_done_cyc", done_q[0], t0 + 3);

        // Max length with source address wrap, W=128
        launch(1'b1, 4'd10, 10'd1021, 10'd50, t0);
        wait_done(1, 300);
        chk("wrap_rd_cnt", rd_a_q.size(), 128);
        chk("wrap_rd_a3", rd_a_q[3], 0);
        chk("wrap_rd_b0", rd_b_q[0], 125);
        chk("wrap_rd_a127", rd_a_q[127], 124);
        chk("wrap_rd_b127", rd_b_q[127], 252);
        chk("wrap_wr_cnt", wr_a_q.size(), 128);
        bad = 0;
        for (int i = 0; i < wr_a_q.size(); i++)
            if (wr_a_q[i] != 50 + i) bad++;
        chk("wrap_wr_seq", bad, 0);
        chk("wrap_done_cyc", done_q[0], t0 + 130);
        chk("wrap_busy_cnt", busy_cnt, 130);

        // Illegal lengths
        launch(1'b1, 4'(LOG_P), 10'd100, 10'd200, t0);
        repeat (4) @(negedge clk);
        chk("ill_lo_err_cnt", err_q.size(), 1);
        chk("ill_lo_err_cyc", err_q[0], t0 + 1);
        chk("ill_lo_rd", rd_a_q.size(), 0);
        chk("ill_lo_wr", wr_a_q.size(), 0);
        chk("ill_lo_busy", busy_cnt, 0);
        launch(1'b0, 4'(MAX_LOG_LEN + 1), 10'd100, 10'd200, t0);
        repeat (4) @(negedge clk);
        chk("ill_hi_err_cnt", err_q.size(), 1);
        chk("ill_hi_err_cyc", err_q[0], t0 + 1);
        chk("ill_hi_rd", rd_a_q.size(), 0);
        chk("ill_hi_wr", wr_a_q.size(), 0);
        chk("ill_hi_busy", busy_cnt, 0);

        // Back-to-back with start held; dst_base changed while busy
        @(posedge clk); #1;
        clr();
        is_f = 1'b1; log_len = 4'd3; src_base = 10'd300; dst_base = 10'd500; start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        dst_base = 10'd600;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, 50);
        chk("b2b_wr_cnt", wr_a_q.size(), 2);
        chk("b2b_wr0_addr", wr_a_q[0], 500);
        chk("b2b_wr0_data", 32'(wr_d_q[0]), 32'(pk(1, -5, 20, 3)));
        chk("b2b_rd1_cyc", rd_c_q[1], t0 + 5);
        chk("b2b_wr1_addr", wr_a_q[1], 600);
        chk("b2b_wr1_cyc", wr_c_q[1], t0 + 7);
        chk("b2b_done1_cyc", done_q[1], t0 + 7);

        // Reset in the middle of RUN
        launch(1'b1, 4'd5, 10'd100, 10'd700, t0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        repeat (8) @(negedge clk);
        chk("rstrun_wr_cnt", wr_a_q.size(), 0);
        chk("rstrun_quiet", nz_cnt, 0);
        launch(1'b1, 4'd4, 10'd100, 10'd200, t0);
        wait_done(1, 50);
        chk("rstrun_fresh_wr_cnt", wr_a_q.size(), 2);
        chk("rstrun_fresh_data", 32'(wr_d_q[0]), 32'(pk(-2, 3, -31, -4)));
        chk("rstrun_fresh_done", done_q[0], t0 + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
